// File: rtl/proj_minhash_sketch.sv
// MinHash sketch builder: hashes one k-mer per cycle with a seeded multiply-xor
// hash and emits (min, position, count) once per window of WINDOW k-mers, or
// earlier when flushed.
module proj_minhash_sketch #(
    parameter int unsigned KMER_BYTES = 4,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned HASH_BITS  = 32,
    parameter int unsigned WINDOW     = 64,
    parameter logic [31:0] SEED       = 32'h9E37_79B9,
    parameter logic [31:0] MULT       = 32'h85EB_CA6B
) (
    input  logic                               in_clk,
    input  logic                               in_rst_n,
    input  logic                               in_valid,
    input  logic [KMER_BYTES*DATA_BITS-1:0]    in_kmer,
    input  logic                               in_flush,
    output logic                               out_valid,
    output logic [HASH_BITS-1:0]               out_min,
    output logic [$clog2(WINDOW)-1:0]          out_pos,
    output logic [$clog2(WINDOW+1)-1:0]        out_count
);

    localparam int unsigned KW = KMER_BYTES * DATA_BITS;
    localparam int unsigned PW = $clog2(WINDOW);
    localparam int unsigned CW = $clog2(WINDOW + 1);

    localparam logic [KW-1:0] SEED_K = KW'(SEED);
    localparam logic [KW-1:0] MULT_K = KW'(MULT);
    localparam logic [PW-1:0] LAST   = PW'(WINDOW - 1);

    // Stage 1 state
    logic                 s1_valid;
    logic                 s1_flush;
    logic [HASH_BITS-1:0] s1_hash;

    // Stage 2 running window state
    logic [PW-1:0]        cnt;
    logic [HASH_BITS-1:0] run_min;
    logic [PW-1:0]        run_pos;

    // Stage 2 combinational results
    logic [KW-1:0]        mix;
    logic [KW-1:0]        prod;
    logic [HASH_BITS-1:0] hash;
    logic                 take_min;
    logic [HASH_BITS-1:0] upd_min;
    logic [PW-1:0]        upd_pos;
    logic [CW-1:0]        upd_count;
    logic                 close;
    logic                 emit;
    logic [PW-1:0]        cnt_next;

    // Hash: product kept modulo 2^KW, top HASH_BITS bits taken
    always_comb begin
        mix  = in_kmer ^ SEED_K;
        prod = mix * MULT_K;
        hash = prod[KW-1 -: HASH_BITS];
    end

    // Stage 1 register: hash plus order-preserving valid/flush bits
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            s1_valid <= 1'b0;
            s1_flush <= 1'b0;
            s1_hash  <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_flush <= in_flush;
            if (in_valid) begin
                s1_hash <= hash;
            end
        end
    end

    // Stage 2 combinational update; strict compare keeps the earliest tie
    always_comb begin
        take_min  = s1_valid && ((cnt == '0) || (s1_hash < run_min));
        upd_min   = take_min ? s1_hash : run_min;
        upd_pos   = take_min ? cnt : run_pos;
        upd_count = CW'(cnt) + CW'(s1_valid);
        close     = (s1_valid && (cnt == LAST)) || s1_flush;
        emit      = close && (upd_count != '0);
        cnt_next  = cnt;
        if (close) begin
            cnt_next = '0;
        end else if (s1_valid) begin
            cnt_next = cnt + PW'(1);
        end
    end

    // Stage 2 register: running min/pos/count and the sketch output
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt       <= '0;
            run_min   <= '0;
            run_pos   <= '0;
            out_valid <= 1'b0;
            out_min   <= '0;
            out_pos   <= '0;
            out_count <= '0;
        end else begin
            cnt       <= cnt_next;
            run_min   <= upd_min;
            run_pos   <= upd_pos;
            out_valid <= emit;
            if (emit) begin
                out_min   <= upd_min;
                out_pos   <= upd_pos;
                out_count <= upd_count;
            end
        end
    end

endmodule

// File: tb/tb_proj_minhash_sketch.sv
// Directed bench for proj_minhash_sketch: an identity-hash instance (WINDOW=4)
// for hand-computed vectors and a default-hash instance (WINDOW=8) checked
// against a small reference model.
module tb_proj_minhash_sketch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_kmer;
    logic        in_flush;

    logic        a_valid;
    logic [31:0] a_min;
    logic [1:0]  a_pos;
    logic [2:0]  a_count;

    logic        b_valid;
    logic [31:0] b_min;
    logic [2:0]  b_pos;
    logic [3:0]  b_count;

    // Outputs captured at the negedge just before new stimulus is applied
    logic        oa_valid;
    logic [31:0] oa_min;
    logic [1:0]  oa_pos;
    logic [2:0]  oa_count;
    logic        ob_valid;
    logic [31:0] ob_min;
    logic [2:0]  ob_pos;
    logic [3:0]  ob_count;

    int checks;
    int failures;

    proj_minhash_sketch #(
        .WINDOW (4),
        .SEED   (32'h0),
        .MULT   (32'h1)
    ) dut_a (
        .in_clk    (clk),
        .in_rst_n  (rst_n),
        .in_valid  (in_valid),
        .in_kmer   (in_kmer),
        .in_flush  (in_flush),
        .out_valid (a_valid),
        .out_min   (a_min),
        .out_pos   (a_pos),
        .out_count (a_count)
    );

    proj_minhash_sketch #(
        .WINDOW (8)
    ) dut_b (
        .in_clk    (clk),
        .in_rst_n  (rst_n),
        .in_valid  (in_valid),
        .in_kmer   (in_kmer),
        .in_flush  (in_flush),
        .out_valid (b_valid),
        .out_min   (b_min),
        .out_pos   (b_pos),
        .out_count (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_hash(input logic [31:0] k);
        logic [31:0] x;
        logic [31:0] p;
        x = k ^ 32'h9E37_79B9;
        p = x * 32'h85EB_CA6B;
        return p;
    endfunction

    // One cycle: capture outputs, then drive inputs for the next posedge.
    // Stimulus applied at tick c shows up in the capture of tick c+2.
    task automatic tick(input logic v, input logic [31:0] k, input logic f);
        @(negedge clk);
        oa_valid = a_valid;
        oa_min   = a_min;
        oa_pos   = a_pos;
        oa_count = a_count;
        ob_valid = b_valid;
        ob_min   = b_min;
        ob_pos   = b_pos;
        ob_count = b_count;
        in_valid = v;
        in_kmer  = k;
        in_flush = f;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_kmer  = '0;
        in_flush = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (a_valid !== 1'b0 || a_min !== 32'd0 || a_pos !== 2'd0 || a_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_a: got v=%b min=%0d pos=%0d cnt=%0d, want all 0",
                     a_valid, a_min, a_pos, a_count);
        end
        checks++;
        if (b_valid !== 1'b0 || b_min !== 32'd0 || b_pos !== 3'd0 || b_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_b: got v=%b min=%0d pos=%0d cnt=%0d, want all 0",
                     b_valid, b_min, b_pos, b_count);
        end
        rst_n = 1'b1;
    endtask

    // 5,3,7,3: tie on 3 keeps position 1
    task automatic test_single_window();
        logic [31:0] ks [8];
        ks = '{5, 3, 7, 3, 0, 0, 0, 0};
        for (int c = 0; c < 7; c++) begin
            tick(c < 4, ks[c], 1'b0);
            checks++;
            if (oa_valid !== (c == 5)) begin
                failures++;
                $display("FAIL single_valid t=%0d: got %b want %b", c, oa_valid, c == 5);
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (oa_min !== 32'd3 || oa_pos !== 2'd1 || oa_count !== 3'd4) begin
                    failures++;
                    $display("FAIL single_elem t=%0d: got min=%0d pos=%0d cnt=%0d want 3/1/4",
                             c, oa_min, oa_pos, oa_count);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ks [12];
        ks = '{9, 8, 7, 6, 1, 2, 3, 4, 0, 0, 0, 0};
        for (int c = 0; c < 11; c++) begin
            tick(c < 8, ks[c], 1'b0);
            checks++;
            if (oa_valid !== (c == 5 || c == 9)) begin
                failures++;
                $display("FAIL b2b_valid t=%0d: got %b want %b", c, oa_valid, c == 5 || c == 9);
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (oa_min !== 32'd6 || oa_pos !== 2'd3 || oa_count !== 3'd4) begin
                    failures++;
                    $display("FAIL b2b_first t=%0d: got min=%0d pos=%0d cnt=%0d want 6/3/4",
                             c, oa_min, oa_pos, oa_count);
                end
            end
            if (c == 9) begin
                checks++;
                if (oa_min !== 32'd1 || oa_pos !== 2'd0 || oa_count !== 3'd4) begin
                    failures++;
                    $display("FAIL b2b_second: got min=%0d pos=%0d cnt=%0d want 1/0/4",
                             oa_min, oa_pos, oa_count);
                end
            end
        end
    endtask

    // 10,4, flush-only -> (4,1,2); second flush-only on empty window -> nothing
    task automatic test_flush();
        logic        vs [10];
        logic [31:0] ks [10];
        logic        fs [10];
        vs = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        ks = '{10, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        fs = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
        for (int c = 0; c < 9; c++) begin
            tick(vs[c], ks[c], fs[c]);
            checks++;
            if (oa_valid !== (c == 4)) begin
                failures++;
                $display("FAIL flush_valid t=%0d: got %b want %b", c, oa_valid, c == 4);
            end
            if (c == 4 || c == 8) begin
                checks++;
                if (oa_min !== 32'd4 || oa_pos !== 2'd1 || oa_count !== 3'd2) begin
                    failures++;
                    $display("FAIL flush_elem t=%0d: got min=%0d pos=%0d cnt=%0d want 4/1/2",
                             c, oa_min, oa_pos, oa_count);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] ks [8];
        ks = '{20, 21, 22, 23, 0, 0, 0, 0};
        tick(1'b1, 32'd50, 1'b0);
        tick(1'b1, 32'd60, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_flush = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || a_min !== 32'd0 || a_pos !== 2'd0 || a_count !== 3'd0) begin
            failures++;
            $display("FAIL midreset_outs: got v=%b min=%0d pos=%0d cnt=%0d want all 0",
                     a_valid, a_min, a_pos, a_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick(c < 4, ks[c], 1'b0);
            checks++;
            if (oa_valid !== (c == 5)) begin
                failures++;
                $display("FAIL midreset_valid t=%0d: got %b want %b", c, oa_valid, c == 5);
            end
            if (c == 5) begin
                checks++;
                if (oa_min !== 32'd20 || oa_pos !== 2'd0 || oa_count !== 3'd4) begin
                    failures++;
                    $display("FAIL midreset_elem: got min=%0d pos=%0d cnt=%0d want 20/0/4",
                             oa_min, oa_pos, oa_count);
                end
            end
        end
    endtask

    task automatic test_random();
        localparam int N = 300;
        logic        ev   [N+2];
        logic [31:0] emin [N+2];
        logic [2:0]  epos [N+2];
        logic [3:0]  ecnt [N+2];
        int          cnt_m;
        int          pos_m;
        int          pulses;
        logic [31:0] min_m;
        logic [31:0] h;
        logic        v;
        logic        f;
        logic [31:0] k;
        cnt_m  = 0;
        pos_m  = 0;
        min_m  = '0;
        pulses = 0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < N + 2; c++) begin
            if (c < N) begin
                v = ($urandom_range(3) != 0);
                f = ($urandom_range(15) == 0);
                k = $urandom;
            end else begin
                v = 1'b0;
                f = 1'b0;
                k = '0;
            end
            tick(v, k, f);
            if (c >= 2) begin
                checks++;
                if (ob_valid !== ev[c-2]) begin
                    failures++;
                    $display("FAIL rand_valid t=%0d: got %b want %b", c, ob_valid, ev[c-2]);
                end
                if (ev[c-2]) begin
                    pulses++;
                    checks++;
                    if (ob_min !== emin[c-2] || ob_pos !== epos[c-2] || ob_count !== ecnt[c-2])
                    begin
                        failures++;
                        $display("FAIL rand_elem t=%0d: got %h/%0d/%0d want %h/%0d/%0d", c,
                                 ob_min, ob_pos, ob_count, emin[c-2], epos[c-2], ecnt[c-2]);
                    end
                end
            end
            ev[c]   = 1'b0;
            emin[c] = '0;
            epos[c] = '0;
            ecnt[c] = '0;
            if (v) begin
                h = ref_hash(k);
                if (cnt_m == 0 || h < min_m) begin
                    min_m = h;
                    pos_m = cnt_m;
                end
                cnt_m++;
            end
            if ((v && cnt_m == 8) || f) begin
                if (cnt_m > 0) begin
                    ev[c]   = 1'b1;
                    emin[c] = min_m;
                    epos[c] = 3'(pos_m);
                    ecnt[c] = 4'(cnt_m);
                end
                cnt_m = 0;
            end
        end
        checks++;
        if (pulses < 10) begin
            failures++;
            $display("FAIL rand_pulses: got %0d want at least 10", pulses);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_window();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
